// File: rtl/icache_responder.sv
// icache_responder: far end of the fetch-side icache request interface.
// Direct-mapped, VIPT, 4 KB instruction cache. Hits answer one cycle after
// the request; misses and uncached fetches go out through a burst read port
// and are answered from the refill line buffer. Also executes the CACOP
// index-invalidate and hit-invalidate operations.
module icache_responder #(
  parameter int OFFSET_W = 4,  // log2 of line size in bytes
  parameter int INDEX_W  = 8   // set index width; OFFSET_W + INDEX_W == 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_icache,
  input  logic [11:0] icache_idx,
  input  logic [2:0]  icache_op,
  input  logic        icache_is_cached,
  input  logic [31:0] icache_pa,
  output logic [31:0] icache_data,
  output logic        icache_data_valid,
  output logic        icache_busy,
  output logic        mem_rd_req,
  output logic        mem_rd_type,
  output logic [31:0] mem_rd_addr,
  input  logic        mem_rd_rdy,
  input  logic        mem_ret_valid,
  input  logic        mem_ret_last,
  input  logic [31:0] mem_ret_data
);

  localparam int WSEL_W     = OFFSET_W - 2;
  localparam int LINE_WORDS = 2 ** WSEL_W;
  localparam int SETS       = 2 ** INDEX_W;
  localparam int TAG_LSB    = OFFSET_W + INDEX_W;
  localparam int TAG_W      = 32 - TAG_LSB;

  localparam logic [WSEL_W-1:0] LAST_BEAT = WSEL_W'(LINE_WORDS - 1);

  // Request opcodes; unlisted encodings behave as NONE.
  localparam logic [2:0] OP_READ    = 3'b001;
  localparam logic [2:0] OP_IDX_INV = 3'b010;
  localparam logic [2:0] OP_HIT_INV = 3'b011;

  // Controller states.
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOOKUP = 3'd1;
  localparam logic [2:0] S_MISS   = 3'd2;
  localparam logic [2:0] S_REFILL = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  logic [2:0] state;
  logic [2:0] state_nx;

  // Cache storage: valid bits are flops with reset, tag/data are plain arrays.
  logic [SETS-1:0]                valid;
  logic [TAG_W-1:0]               tag_mem  [SETS];
  logic [LINE_WORDS-1:0][31:0]    data_mem [SETS];

  // Captured request (taken at the accept edge).
  logic               req_read;
  logic               req_hit_inv;
  logic               req_cached;
  logic [31:2]        req_pa;
  logic [INDEX_W-1:0] req_set;

  // Array read results for the accepted request.
  logic [TAG_W-1:0]   rd_tag;
  logic [31:0]        rd_word;

  // Refill bookkeeping.
  logic [WSEL_W-1:0]           beat_cnt;
  logic [LINE_WORDS-1:0][31:0] line_buf;
  logic [LINE_WORDS-1:0][31:0] fill_line;

  // Decode and handshake terms.
  logic               op_read;
  logic               op_idx_inv;
  logic               op_hit_inv;
  logic               op_valid;
  logic               accept;
  logic [INDEX_W-1:0] acc_set;
  logic [WSEL_W-1:0]  acc_word;
  logic               in_lookup;
  logic               lookup_hit;
  logic               read_hit;
  logic               read_miss;
  logic               in_refill;
  logic               beat;
  logic               refill_done;
  logic               fill_en;
  logic [31:0]        resp_word;

  assign op_read    = (icache_op == OP_READ);
  assign op_idx_inv = (icache_op == OP_IDX_INV);
  assign op_hit_inv = (icache_op == OP_HIT_INV);
  assign op_valid   = op_read | op_idx_inv | op_hit_inv;
  assign accept     = op_valid & ~icache_busy & ~stall_icache;

  assign acc_set  = icache_idx[TAG_LSB-1:OFFSET_W];
  assign acc_word = icache_idx[OFFSET_W-1:2];

  // Valid is read live so a HIT_INV or IDX_INV retired at the previous edge
  // is already visible to the lookup that follows it.
  assign in_lookup  = (state == S_LOOKUP);
  assign lookup_hit = valid[req_set] & (rd_tag == req_pa[31:TAG_LSB]) & req_cached;
  assign read_hit   = in_lookup & req_read & lookup_hit;
  assign read_miss  = in_lookup & req_read & ~lookup_hit;

  // A cached refill completes on the counter, an uncached one on its only beat.
  assign in_refill   = (state == S_REFILL);
  assign beat        = in_refill & mem_ret_valid;
  assign refill_done = beat & (~req_cached | (beat_cnt == LAST_BEAT));
  assign fill_en     = refill_done & req_cached;

  assign resp_word = req_cached ? line_buf[req_pa[OFFSET_W-1:2]] : line_buf[0];

  assign icache_busy       = (state == S_MISS) | in_refill | (state == S_RESP) | read_miss;
  assign icache_data_valid = read_hit | (state == S_RESP);
  assign icache_data       = read_hit           ? rd_word   :
                             (state == S_RESP)  ? resp_word : 32'h0;

  assign mem_rd_req  = (state == S_MISS);
  assign mem_rd_type = (state == S_MISS) & req_cached;
  assign mem_rd_addr = (state != S_MISS) ? 32'h0 :
                       req_cached        ? {req_pa[31:OFFSET_W], {OFFSET_W{1'b0}}} :
                                           {req_pa[31:2], 2'b00};

  // The return-last flag carries no extra information (the beat counter
  // decides completion) and the byte-offset bits never select anything.
  logic unused_inputs;
  assign unused_inputs = ^{mem_ret_last, icache_pa[1:0], icache_idx[1:0]};

  // Line image written into the data array: buffered beats plus the final one.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    fill_line           = line_buf;
    fill_line[beat_cnt] = mem_ret_data;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (accept) state_nx = op_idx_inv ? S_IDLE : S_LOOKUP;
      end
      S_LOOKUP: begin
        if (read_miss)                      state_nx = S_MISS;
        else if (req_read && stall_icache)  state_nx = S_LOOKUP;
        else if (accept)                    state_nx = op_idx_inv ? S_IDLE : S_LOOKUP;
        else                                state_nx = S_IDLE;
      end
      S_MISS: begin
        if (mem_rd_rdy) state_nx = S_REFILL;
      end
      S_REFILL: begin
        if (refill_done) state_nx = S_RESP;
      end
      S_RESP: begin
        if (!stall_icache) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State register, captured request and refill beat counter.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      req_read    <= 1'b0;
      req_hit_inv <= 1'b0;
      req_cached  <= 1'b0;
      req_pa      <= '0;
      req_set     <= '0;
      beat_cnt    <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        req_read    <= op_read;
        req_hit_inv <= op_hit_inv;
        req_cached  <= icache_is_cached;
        req_pa      <= icache_pa[31:2];
        req_set     <= acc_set;
      end
      if (state == S_MISS)  beat_cnt <= '0;
      else if (beat)        beat_cnt <= beat_cnt + 1'b1;
    end
  end

  // Valid bits: cleared by reset and both invalidate ops, set by a cached fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else begin
      if (accept && op_idx_inv)             valid[acc_set] <= 1'b0;
      if (in_lookup && req_hit_inv && lookup_hit) valid[req_set] <= 1'b0;
      if (fill_en)                          valid[req_set] <= 1'b1;
    end
  end

  // Tag/data arrays, accept-time array reads and the refill line buffer.
  // NOTE: storage arrays are deliberately left out of reset; the valid bits
  // alone decide whether their contents mean anything.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_mem[req_set]  <= req_pa[31:TAG_LSB];
      data_mem[req_set] <= fill_line;
    end
    if (accept) begin
      rd_tag  <= tag_mem[acc_set];
      rd_word <= data_mem[acc_set][acc_word];
    end
    if (beat) line_buf[beat_cnt] <= mem_ret_data;
  end

endmodule

// File: tb/tb_icache_responder.sv
// Self-checking bench for icache_responder: a table of directed fetches,
// hand-written multi-cycle sequences (back-to-back hits, stall hold, reset
// during refill) and a randomized run against a set/tag reference model.
module tb_icache_responder;

  localparam logic [2:0] OP_NONE    = 3'b000;
  localparam logic [2:0] OP_READ    = 3'b001;
  localparam logic [2:0] OP_IDX_INV = 3'b010;
  localparam logic [2:0] OP_HIT_INV = 3'b011;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_icache = 1'b0;
  logic [11:0] icache_idx = '0;
  logic [2:0]  icache_op = OP_NONE;
  logic        icache_is_cached = 1'b0;
  logic [31:0] icache_pa = '0;
  logic [31:0] icache_data;
  logic        icache_data_valid;
  logic        icache_busy;
  logic        mem_rd_req;
  logic        mem_rd_type;
  logic [31:0] mem_rd_addr;
  logic        mem_rd_rdy;
  logic        mem_ret_valid;
  logic        mem_ret_last;
  logic [31:0] mem_ret_data;

  icache_responder dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .stall_icache      (stall_icache),
    .icache_idx        (icache_idx),
    .icache_op         (icache_op),
    .icache_is_cached  (icache_is_cached),
    .icache_pa         (icache_pa),
    .icache_data       (icache_data),
    .icache_data_valid (icache_data_valid),
    .icache_busy       (icache_busy),
    .mem_rd_req        (mem_rd_req),
    .mem_rd_type       (mem_rd_type),
    .mem_rd_addr       (mem_rd_addr),
    .mem_rd_rdy        (mem_rd_rdy),
    .mem_ret_valid     (mem_ret_valid),
    .mem_ret_last      (mem_ret_last),
    .mem_ret_data      (mem_ret_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // Backing memory: a few pinned words, everything else derived from the address.
  logic [31:0] mem_ovr [logic [31:0]];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_ovr.exists(a)) return mem_ovr[a];
    return {a[15:0], ~a[31:16]};
  endfunction

  // AXI bridge model: random accept delay, optional beat gaps, beat limit
  // used to freeze a refill half way.
  int          req_cnt = 0;
  int          beats_sent = 0;
  int          beat_limit = 1000;
  logic [31:0] last_addr = '0;
  logic        last_type = 1'b0;

  initial begin : bridge
    logic [31:0] a;
    logic        t;
    int          n;
    int          d;
    mem_rd_rdy    = 1'b0;
    mem_ret_valid = 1'b0;
    mem_ret_last  = 1'b0;
    mem_ret_data  = '0;
    forever begin
      @(negedge clk);
      if (mem_rd_req && rst_n) begin
        a = mem_rd_addr;
        t = mem_rd_type;
        d = $urandom_range(0, 2);
        for (int i = 0; i < d; i++) begin
          @(negedge clk);
          check("req_held", mem_rd_req, 1);
          check("addr_held", mem_rd_addr, a);
          check("type_held", mem_rd_type, t);
        end
        mem_rd_rdy = 1'b1;
        @(negedge clk);
        mem_rd_rdy = 1'b0;
        req_cnt++;
        last_addr = a;
        last_type = t;
        n = t ? 4 : 1;
        for (int i = 0; i < n && i < beat_limit; i++) begin
          if ($urandom_range(0, 3) == 0) @(negedge clk);
          mem_ret_valid = 1'b1;
          mem_ret_data  = mem_word(a + 32'(4 * i));
          mem_ret_last  = (i == n - 1);
          @(negedge clk);
          beats_sent++;
          mem_ret_valid = 1'b0;
          mem_ret_last  = 1'b0;
        end
      end
    end
  end

  task automatic drive(input logic [2:0] op, input logic [31:0] pa, input bit cached);
    icache_op        = op;
    icache_pa        = pa;
    icache_idx       = pa[11:0];
    icache_is_cached = cached;
  endtask

  // Present one op, wait for acceptance, then collect the response.
  task automatic do_op(input logic [2:0] op, input logic [31:0] pa, input bit cached,
                       output bit got_valid, output logic [31:0] got_data,
                       output int lat, output int nreq, output bit busy1);
    int guard;
    int start_req;
    int max_wait;
    @(negedge clk);
    drive(op, pa, cached);
    guard = 0;
    while (icache_busy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("accept_wait", guard < 200, 1);
    start_req = req_cnt;
    @(negedge clk);
    drive(OP_NONE, 32'h0, 1'b0);
    busy1    = icache_busy;
    lat      = 1;
    max_wait = (op == OP_READ) ? 200 : 3;
    while (!icache_data_valid && lat < max_wait) begin
      @(negedge clk);
      lat++;
    end
    got_valid = icache_data_valid;
    got_data  = icache_data;
    if (got_valid) begin
      @(negedge clk);
      check("pulse_once", icache_data_valid, 0);
    end
    nreq = req_cnt - start_req;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] pa;
    bit          cached;
    bit          miss;
    logic [31:0] data;
    logic [31:0] addr;
  } vec_t;

  vec_t vecs[10];

  // Reference model: which tag each set holds, if any.
  bit          mv [256];
  logic [19:0] mt [256];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    bit          gv;
    logic [31:0] gd;
    int          lat;
    int          nreq;
    bit          b1;
    int          b0;
    int          guard;
    logic [19:0] tpool [4];
    logic [7:0]  spool [4];

    mem_ovr[32'h1C000010] = 32'h0000_00A0;
    mem_ovr[32'h1C000014] = 32'h0000_00A1;
    mem_ovr[32'h1C000018] = 32'h0000_00A2;
    mem_ovr[32'h1C00001C] = 32'h0000_00A3;
    mem_ovr[32'h1FD00004] = 32'h0000_0055;

    //          op          pa            c  miss data          req addr
    vecs[0] = '{OP_READ,    32'h1C000010, 1, 1, 32'h000000A0, 32'h1C000010};
    vecs[1] = '{OP_READ,    32'h1C000014, 1, 0, 32'h000000A1, 32'h0};
    vecs[2] = '{OP_READ,    32'h1FD00004, 0, 1, 32'h00000055, 32'h1FD00004};
    vecs[3] = '{OP_READ,    32'h1FD00004, 0, 1, 32'h00000055, 32'h1FD00004};
    vecs[4] = '{OP_HIT_INV, 32'h2C000014, 1, 0, 32'h0,        32'h0};
    vecs[5] = '{OP_READ,    32'h1C00001C, 1, 0, 32'h000000A3, 32'h0};
    vecs[6] = '{OP_IDX_INV, 32'h00000010, 1, 0, 32'h0,        32'h0};
    vecs[7] = '{OP_READ,    32'h1C000010, 1, 1, 32'h000000A0, 32'h1C000010};
    vecs[8] = '{OP_HIT_INV, 32'h1C000018, 1, 0, 32'h0,        32'h0};
    vecs[9] = '{OP_READ,    32'h1C000018, 1, 1, 32'h000000A2, 32'h1C000010};

    // Reset state.
    #3;
    check("rst_data", icache_data, 0);
    check("rst_valid", icache_data_valid, 0);
    check("rst_busy", icache_busy, 0);
    check("rst_req", mem_rd_req, 0);
    check("rst_type", mem_rd_type, 0);
    check("rst_addr", mem_rd_addr, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed table.
    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].op, vecs[i].pa, vecs[i].cached, gv, gd, lat, nreq, b1);
      check($sformatf("v%0d_busy_t1", i), b1, vecs[i].miss);
      check($sformatf("v%0d_nreq", i), nreq, vecs[i].miss ? 1 : 0);
      if (vecs[i].op == OP_READ) begin
        check($sformatf("v%0d_valid", i), gv, 1);
        check($sformatf("v%0d_data", i), gd, vecs[i].data);
        if (vecs[i].miss) begin
          check($sformatf("v%0d_addr", i), last_addr, vecs[i].addr);
          check($sformatf("v%0d_type", i), last_type, vecs[i].cached);
        end else begin
          check($sformatf("v%0d_hit_lat", i), lat, 1);
        end
      end else begin
        check($sformatf("v%0d_no_valid", i), gv, 0);
      end
    end

    // Back-to-back hits on the resident line: one response per cycle.
    b0 = req_cnt;
    @(negedge clk);
    drive(OP_READ, 32'h1C000010, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("b2b_valid%0d", k), icache_data_valid, 1);
      check($sformatf("b2b_data%0d", k), icache_data, 32'hA0 + 32'(k));
      check($sformatf("b2b_busy%0d", k), icache_busy, 0);
      if (k < 3) drive(OP_READ, 32'h1C000014 + 32'(4 * k), 1'b1);
      else       drive(OP_NONE, 32'h0, 1'b0);
    end
    @(negedge clk);
    check("b2b_end_valid", icache_data_valid, 0);
    check("b2b_no_req", req_cnt - b0, 0);

    // Hit held through a 3-cycle stall; the op offered meanwhile is dropped.
    drive(OP_READ, 32'h1C000014, 1'b1);
    @(negedge clk);
    check("stall_valid0", icache_data_valid, 1);
    check("stall_data0", icache_data, 32'hA1);
    stall_icache = 1'b1;
    drive(OP_READ, 32'h1C000018, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check($sformatf("stall_valid%0d", k), icache_data_valid, 1);
      check($sformatf("stall_data%0d", k), icache_data, 32'hA1);
    end
    stall_icache = 1'b0;
    drive(OP_NONE, 32'h0, 1'b0);
    @(negedge clk);
    check("stall_op_dropped", icache_data_valid, 0);
    check("stall_idle_busy", icache_busy, 0);

    // Reset while a refill is half delivered.
    beat_limit = 2;
    b0 = beats_sent;
    drive(OP_READ, 32'h1C000020, 1'b1);
    @(negedge clk);
    drive(OP_NONE, 32'h0, 1'b0);
    guard = 0;
    while (beats_sent < b0 + 2 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("rst_mid_beats", beats_sent - b0, 2);
    check("rst_mid_busy_before", icache_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_busy", icache_busy, 0);
    check("rst_mid_req", mem_rd_req, 0);
    check("rst_mid_valid", icache_data_valid, 0);
    check("rst_mid_data", icache_data, 0);
    check("rst_mid_addr", mem_rd_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    beat_limit = 1000;
    do_op(OP_READ, 32'h1C000020, 1'b1, gv, gd, lat, nreq, b1);
    check("post_rst_partial_miss", nreq, 1);
    check("post_rst_partial_data", gd, mem_word(32'h1C000020));
    do_op(OP_READ, 32'h1C000010, 1'b1, gv, gd, lat, nreq, b1);
    check("post_rst_line_miss", nreq, 1);
    check("post_rst_line_data", gd, 32'hA0);

    // Randomized run against the set/tag model.
    for (int s = 0; s < 256; s++) mv[s] = 1'b0;
    mv[8'h02] = 1'b1; mt[8'h02] = 20'h1C000;
    mv[8'h01] = 1'b1; mt[8'h01] = 20'h1C000;
    tpool = '{20'h1C000, 20'h1C001, 20'h2A5A5, 20'h00003};
    spool = '{8'h00, 8'h01, 8'h02, 8'h80};
    for (int k = 0; k < 150; k++) begin
      logic [31:0] pa;
      logic [2:0]  op;
      logic [1:0]  w;
      logic [7:0]  set;
      bit          cached;
      bit          hit;
      int          r;
      w      = 2'($urandom_range(0, 3));
      pa     = {tpool[$urandom_range(0, 3)], spool[$urandom_range(0, 3)], w, 2'b00};
      set    = pa[11:4];
      cached = ($urandom_range(0, 4) != 0);
      r      = $urandom_range(0, 19);
      if (r < 15)      op = OP_READ;
      else if (r < 17) op = OP_HIT_INV;
      else if (r < 19) op = OP_IDX_INV;
      else             op = 3'(4 + $urandom_range(0, 3));
      hit = cached && mv[set] && (mt[set] == pa[31:12]);
      do_op(op, pa, cached, gv, gd, lat, nreq, b1);
      if (op == OP_READ) begin
        check("rnd_valid", gv, 1);
        check("rnd_data", gd, mem_word({pa[31:2], 2'b00}));
        check("rnd_nreq", nreq, hit ? 0 : 1);
        check("rnd_busy_t1", b1, !hit);
        if (!hit) begin
          check("rnd_addr", last_addr, cached ? {pa[31:4], 4'h0} : {pa[31:2], 2'b00});
          check("rnd_type", last_type, cached);
          if (cached) begin
            mv[set] = 1'b1;
            mt[set] = pa[31:12];
          end
        end else begin
          check("rnd_hit_lat", lat, 1);
        end
      end else begin
        check("rnd_no_valid", gv, 0);
        check("rnd_no_req", nreq, 0);
        if (op == OP_IDX_INV) mv[set] = 1'b0;
        if (op == OP_HIT_INV && hit) mv[set] = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
